// File: rtl/palette_encoder.sv
// palette_encoder
// Maps a 12-bit RGB444 pixel to the index of the nearest entry (Manhattan
// distance) in a writable 16-entry palette. Entries are scanned one per cycle.
// The scan stops early on an exact match. Ties keep the lowest index.
//
// Ports:
//   Clk        system clock, rising edge
//   Reset      synchronous active-high reset; clears FSM, result and palette
//   pal_we     palette write strobe (accepted in every state)
//   pal_waddr  palette entry to write
//   pal_wdata  {r[3:0], g[3:0], b[3:0]}
//   in_valid   in_rgb is valid
//   in_ready   encoder idle and able to accept a pixel
//   in_rgb     pixel to encode, sampled only on acceptance
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   out_index  nearest palette index
//   out_dist   |dr|+|dg|+|db| of the chosen entry
//   out_exact  result valid and out_dist == 0
module palette_encoder #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             pal_we,
    input  logic [IDX_W-1:0] pal_waddr,
    input  logic [11:0]      pal_wdata,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      in_rgb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [5:0]       out_dist,
    output logic             out_exact
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(ENTRIES - 1);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e           state;
    logic [11:0]      pal [ENTRIES];
    logic [11:0]      pix;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] best_idx;
    logic [5:0]       best_dist;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [11:0]      entry;
    logic [5:0]       scan_dist;

    function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // The palette register read here holds its pre-edge value, so a write to the
    // entry being scanned in the same cycle only becomes visible next cycle.
    always_comb begin
        entry     = pal[cnt];
        scan_dist = {2'b00, abs_diff(entry[11:8], pix[11:8])}
                  + {2'b00, abs_diff(entry[7:4],  pix[7:4])}
                  + {2'b00, abs_diff(entry[3:0],  pix[3:0])};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                pal[i] <= '0;
            end
        end else if (pal_we) begin
            pal[pal_waddr] <= pal_wdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= StIdle;
            pix         <= '0;
            cnt         <= '0;
            best_idx    <= '0;
            best_dist   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        pix        <= in_rgb;
                        best_dist  <= 6'h3F;
                        best_idx   <= '0;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= StScan;
                    end
                end
                StScan: begin
                    // Strict compare: an equal distance later in the scan loses.
                    if (scan_dist < best_dist) begin
                        best_dist <= scan_dist;
                        best_idx  <= cnt;
                    end
                    if (scan_dist == 6'd0 || cnt == LastIdx) begin
                        out_valid_q <= 1'b1;
                        state       <= StDone;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_index = best_idx;
    assign out_dist  = best_dist;
    assign out_exact = out_valid_q && (best_dist == 6'd0);

endmodule

// File: tb/tb_palette_encoder.sv
// Directed testbench for palette_encoder. Inputs are driven 1ns after a rising
// edge and outputs sampled at the same point, well away from the active edge.
module tb_palette_encoder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        pal_we;
    logic [3:0]  pal_waddr;
    logic [11:0] pal_wdata;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_rgb;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_index;
    logic [5:0]  out_dist;
    logic        out_exact;

    int checks = 0;
    int errors = 0;

    palette_encoder #(
        .ENTRIES(16),
        .IDX_W  (4)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .pal_we   (pal_we),
        .pal_waddr(pal_waddr),
        .pal_wdata(pal_wdata),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_rgb   (in_rgb),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_index(out_index),
        .out_dist (out_dist),
        .out_exact(out_exact)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pal_write(input logic [3:0] a, input logic [11:0] d);
        pal_we    = 1'b1;
        pal_waddr = a;
        pal_wdata = d;
        tick();
        pal_we    = 1'b0;
    endtask

    // Presents one pixel for one edge, then counts edges until out_valid (bounded).
    // lat is the number of edges after the accept edge at which out_valid is seen.
    task automatic send_pixel(input logic [11:0] rgb, output int lat);
        in_valid = 1'b1;
        in_rgb   = rgb;
        tick();
        in_valid = 1'b0;
        in_rgb   = ~rgb;  // later changes must not affect the scan
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid);
        end
        checks++;
        if (out_index !== 4'd0 || out_dist !== 6'd0 || out_exact !== 1'b0) begin
            errors++;
            $display("FAIL reset_result got idx=%0d dist=%0d exact=%b exp 0/0/0",
                     out_index, out_dist, out_exact);
        end
    endtask

    // Zero palette: 12'h123 is 1+2+3=6 from every entry, full scan, index 0.
    task automatic test_zero_palette();
        int lat;
        send_pixel(12'h123, lat);
        checks++;
        if (lat !== 16) begin
            errors++; $display("FAIL zero_pal_latency got %0d exp 16", lat);
        end
        checks++;
        if (out_index !== 4'd0 || out_dist !== 6'd6 || out_exact !== 1'b0) begin
            errors++;
            $display("FAIL zero_pal_result got idx=%0d dist=%0d exact=%b exp 0/6/0",
                     out_index, out_dist, out_exact);
        end
        take_result();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_pal_release got valid=%b ready=%b exp 0/1", out_valid, in_ready);
        end
    endtask

    task automatic load_palette();
        pal_write(4'd0, 12'h520);
        pal_write(4'd1, 12'h6AF);
        pal_write(4'd2, 12'h940);
        pal_write(4'd3, 12'hFFF);
        pal_write(4'd4, 12'h000);
        for (int i = 5; i < 16; i++) pal_write(4'(i), 12'h6AF);
    endtask

    task automatic test_exact();
        int lat;
        // Exact at entry 2: early stop.
        send_pixel(12'h940, lat);
        checks++;
        if (lat !== 3 || out_index !== 4'd2 || out_dist !== 6'd0 || out_exact !== 1'b1) begin
            errors++;
            $display("FAIL exact_e2 got lat=%0d idx=%0d dist=%0d exact=%b exp 3/2/0/1",
                     lat, out_index, out_dist, out_exact);
        end
        take_result();
        // Exact at entry 0: shortest latency.
        send_pixel(12'h520, lat);
        checks++;
        if (lat !== 1 || out_index !== 4'd0 || out_exact !== 1'b1) begin
            errors++;
            $display("FAIL exact_e0 got lat=%0d idx=%0d exact=%b exp 1/0/1",
                     lat, out_index, out_exact);
        end
        take_result();
        // Exact at entry 4 (black).
        send_pixel(12'h000, lat);
        checks++;
        if (lat !== 5 || out_index !== 4'd4 || out_dist !== 6'd0) begin
            errors++;
            $display("FAIL exact_e4 got lat=%0d idx=%0d dist=%0d exp 5/4/0",
                     lat, out_index, out_dist);
        end
        take_result();
    endtask

    task automatic test_nearest();
        int lat;
        // A50: e0=8, e2=2, e3=30, e4=15, 6AF entries=24.
        send_pixel(12'hA50, lat);
        checks++;
        if (lat !== 16 || out_index !== 4'd2 || out_dist !== 6'd2 || out_exact !== 1'b0) begin
            errors++;
            $display("FAIL nearest_a50 got lat=%0d idx=%0d dist=%0d exact=%b exp 16/2/2/0",
                     lat, out_index, out_dist, out_exact);
        end
        take_result();
        // 6AE: entries 1 and 5..15 tie at 1; lowest index wins.
        send_pixel(12'h6AE, lat);
        checks++;
        if (lat !== 16 || out_index !== 4'd1 || out_dist !== 6'd1) begin
            errors++;
            $display("FAIL tie_6ae got lat=%0d idx=%0d dist=%0d exp 16/1/1",
                     lat, out_index, out_dist);
        end
        take_result();
    endtask

    // A write to an unscanned entry during a scan is seen by that scan.
    task automatic test_write_during_scan();
        int lat;
        in_valid = 1'b1;
        in_rgb   = 12'h123;
        tick();
        in_valid = 1'b0;
        pal_write(4'd15, 12'h123);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 16 || out_index !== 4'd15 || out_dist !== 6'd0 || out_exact !== 1'b1) begin
            errors++;
            $display("FAIL write_in_scan got lat=%0d idx=%0d dist=%0d exact=%b exp 16/15/0/1",
                     lat, out_index, out_dist, out_exact);
        end
        take_result();
        pal_write(4'd15, 12'h6AF);
    endtask

    task automatic test_back_to_back();
        int lat;
        int bad;
        send_pixel(12'h940, lat);
        in_valid = 1'b1;
        in_rgb   = 12'hFFF;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_index !== 4'd2 ||
                out_dist !== 6'd0 || out_exact !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL backpressure_hold got %0d bad cycles exp 0", bad);
        end
        out_ready = 1'b1;
        tick();  // handshake edge R
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_handshake got valid=%b ready=%b exp 0/1", out_valid, in_ready);
        end
        tick();  // R+1 accepts FFF
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL second_accept got ready=%b exp 0", in_ready);
        end
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 4 || out_index !== 4'd3 || out_exact !== 1'b1) begin
            errors++;
            $display("FAIL second_result got lat=%0d idx=%0d exact=%b exp 4/3/1",
                     lat, out_index, out_exact);
        end
        take_result();
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        in_valid = 1'b1;
        in_rgb   = 12'h123;
        tick();  // accept edge T
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();  // now in the cycle evaluating entry 7
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_scan got valid=%b ready=%b exp 0/1", out_valid, in_ready);
        end
        send_pixel(12'hFFF, lat);
        checks++;
        if (lat !== 16 || out_index !== 4'd0 || out_dist !== 6'd45 || out_exact !== 1'b0) begin
            errors++;
            $display("FAIL pal_cleared got lat=%0d idx=%0d dist=%0d exact=%b exp 16/0/45/0",
                     lat, out_index, out_dist, out_exact);
        end
        take_result();
    endtask

    initial begin
        Reset     = 1'b1;
        pal_we    = 1'b0;
        pal_waddr = '0;
        pal_wdata = '0;
        in_valid  = 1'b0;
        in_rgb    = '0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_zero_palette();
        load_palette();
        test_exact();
        test_nearest();
        test_write_during_scan();
        test_back_to_back();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
